// File: rtl/hamming_encode_engine.sv
// (16,11) SECDED encoder engine. Walks data memory: reads each 11-bit message
// as a byte pair from SRC_BASE, encodes it, and writes the 16-bit codeword as
// a byte pair to DST_BASE. Memory read is combinational, write is synchronous.
module hamming_encode_engine #(
  parameter int NUM_MSGS = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        MemRdData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData,
  output logic              Done,
  output logic              Busy
);

  localparam int K_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [7:0]        lo_q, lo_d;
  logic [2:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;

  logic              launch;
  logic [15:0]       cw_cur;
  logic [15:0]       cw_new;

  // Byte address of message/codeword idx within a table at base; odd selects the MSW.
  function automatic logic [ADDR_W-1:0] byte_addr(input int base,
                                                  input logic [K_W-1:0] idx,
                                                  input logic odd);
    return ADDR_W'(base + 2 * int'(idx) + int'(odd));
  endfunction

  // d[10:0] carries message bits d11..d1; returns the SECDED codeword.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    cw       = '0;
    cw[15:9] = d[10:4];
    cw[7:5]  = d[3:1];
    cw[3]    = d[0];
    cw[8]    = ^cw[15:9];
    cw[4]    = ^{cw[15:12], cw[7:5]};
    cw[2]    = ^{cw[15], cw[14], cw[11], cw[10], cw[7], cw[6], cw[3]};
    cw[1]    = ^{cw[15], cw[13], cw[11], cw[9], cw[7], cw[5], cw[3]};
    cw[0]    = ^cw[15:1];
    return cw;
  endfunction

  // Next-state, next-output and datapath decode for the memory walk.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    k_d       = k_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    busy_d    = 1'b0;
    start_d   = Start;

    launch = Start & ~start_q;
    // Low byte is written the cycle after RD_HI, so it is encoded from the live read data.
    cw_new = encode({MemRdData[2:0], lo_q});
    cw_cur = encode({hi_q, lo_q});

    unique case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          state_d = RD_LO;
          k_d     = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          addr_d  = byte_addr(SRC_BASE, '0, 1'b0);
        end
      end
      RD_LO: begin
        lo_d    = MemRdData;
        state_d = RD_HI;
        busy_d  = 1'b1;
        addr_d  = byte_addr(SRC_BASE, k_q, 1'b1);
      end
      RD_HI: begin
        hi_d      = MemRdData[2:0];
        state_d   = WR_LO;
        busy_d    = 1'b1;
        addr_d    = byte_addr(DST_BASE, k_q, 1'b0);
        wr_en_d   = 1'b1;
        wr_data_d = cw_new[7:0];
      end
      WR_LO: begin
        state_d   = WR_HI;
        busy_d    = 1'b1;
        addr_d    = byte_addr(DST_BASE, k_q, 1'b1);
        wr_en_d   = 1'b1;
        wr_data_d = cw_cur[15:8];
      end
      WR_HI: begin
        if (k_q == K_W'(NUM_MSGS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = RD_LO;
          busy_d  = 1'b1;
          addr_d  = byte_addr(SRC_BASE, k_q + 1'b1, 1'b0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset wins over any launch.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
    end
  end

  // Reset blocks the write strobe in the very cycle it arrives, so a reset
  // landing in a write state lets no further byte reach memory.
  assign MemWrEn   = wr_en_q & ~Reset;
  assign MemAddr   = addr_q;
  assign MemWrData = wr_data_q;
  assign Done      = done_q;
  assign Busy      = busy_q;

endmodule

// File: doc/hamming_encode_engine.md
Name: hamming_encode_engine

Overview:
Hardware (16,11) SECDED encoder engine for the program-1 workload. It walks the data memory the same way the program-1 software does. It reads 11-bit messages stored as byte pairs at SRC_BASE.., encodes each one, and writes 16-bit codewords as byte pairs at DST_BASE... It attaches to a data-memory port (combinational read, synchronous write). It is launched by Start and reports completion on Done, so it can stand in for the core or act as a golden model beside it.

Parameters:
NUM_MSGS, 15, number of messages processed per run
SRC_BASE, 0, byte address of message 0 LSW; MSW is at SRC_BASE+1
DST_BASE, 30, byte address of codeword 0 LSW; MSW is at DST_BASE+1
ADDR_W, 8, data-memory address width

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  launch request; a run begins on a 0->1 transition
MemRdData  input  8  data-memory read data, combinational from MemAddr
MemAddr  output  ADDR_W  data-memory address
MemWrEn  output  1  data-memory write enable
MemWrData  output  8  data-memory write data
Done  output  1  run complete (the Ack equivalent)
Busy  output  1  run in progress

Behaviour:
- Reset (sync, active-high) values: state=IDLE, Done=0, Busy=0, MemWrEn=0, MemAddr=0, MemWrData=0, msg counter=0, Start_q=0.
- Start_q is a registered copy of Start. launch = Start & ~Start_q, evaluated only in IDLE or DONE. Start edges in any other state are ignored.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE/DONE -> RD_LO on launch. Launch clears the msg counter k and drops Done on the same edge.
- RD_LO: MemAddr=SRC_BASE+2k; latch lo=MemRdData. Next state RD_HI.
- RD_HI: MemAddr=SRC_BASE+2k+1; latch hi=MemRdData[2:0]. Bits [7:3] are ignored. Next state WR_LO.
- WR_LO: MemAddr=DST_BASE+2k, MemWrEn=1, MemWrData=cw[7:0]. Next state WR_HI.
- WR_HI: MemAddr=DST_BASE+2k+1, MemWrEn=1, MemWrData=cw[15:8].
  - If k==NUM_MSGS-1, go to DONE.
  - Otherwise k<=k+1 and go to RD_LO.
- DONE: Done=1 and stays high until the next launch or Reset. MemWrEn=0.
- Busy=1 in RD_LO..WR_HI. MemWrEn=1 only in WR_LO/WR_HI.
- Encoding: message d[11:1] = {hi[2:0], lo[7:0]}. Codeword bit positions:
  - cw[15:9]=d[11:5], cw[7:5]=d[4:2], cw[3]=d[1]
  - cw[8]=p8, cw[4]=p4, cw[2]=p2, cw[1]=p1, cw[0]=p0
- Parity (XOR reductions, computed combinationally from lo/hi):
  - p8 = ^cw[15:9]
  - p4 = ^{cw[15:12], cw[7:5]}
  - p2 = ^{cw[15],cw[14],cw[11],cw[10],cw[7],cw[6],cw[3]}
  - p1 = ^{cw[15],cw[13],cw[11],cw[9],cw[7],cw[5],cw[3]}
  - p0 = ^cw[15:1], including p8/p4/p2/p1 (overall even parity)
- Latency: launch detected at edge t; first RD_LO in cycle t+1; Done high at cycle t+1+4*NUM_MSGS (61 cycles for the default).
- Exactly 2*NUM_MSGS writes per run, in ascending address order. Source bytes are never written.
- Reset mid-run: IDLE on the next edge, MemWrEn=0 from that cycle on, no further writes. Partial results already written remain in memory.
- Start held high continuously causes exactly one run. A re-run requires Start to fall and rise again.
- Reset and Start high on the same edge: Reset wins, state=IDLE, and Start_q is cleared.

Test Plan:
- Msg0 lo=8'b10011010, hi=8'b00000011; pulse Start -> mem[31:30] = 16'b0111001010110001; Done high 61 cycles after the edge.
- Msg lo=8'hFF, hi=8'h07 -> codeword 16'hFFFF; lo=8'h00, hi=8'h00 -> 16'h0000.
- Same message with hi=8'hFB (garbage in [7:3]) -> same codeword as hi=8'h03; bytes 0..29 unchanged after the run.
- Assert Reset during WR_LO of message 5 -> no writes after that cycle, mem[40..59] retain their prior values, Done=0, Busy=0.
- Hold Start high for 200 cycles -> exactly 30 write strobes. Drop Start, raise it again -> second run; Done falls on the launch edge and reasserts 61 cycles later.
- Random 11-bit messages in all 15 slots -> each codeword matches the reference parity equations; flipping any single bit gives a nonzero syndrome.
